// File: rtl/regfile_writeback.sv
// regfile_writeback: round-robin arbitration of ALU/LSU/MDU results onto the
// register-file write port, plus a per-register pending scoreboard for issue.
module regfile_writeback #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    input  logic [4:0]            alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    output logic                  alu_ready,
    input  logic                  lsu_valid,
    input  logic [4:0]            lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  lsu_ready,
    input  logic                  mdu_valid,
    input  logic [4:0]            mdu_rd,
    input  logic [DATA_WIDTH-1:0] mdu_data,
    output logic                  mdu_ready,
    input  logic                  iss_valid,
    input  logic [4:0]            iss_rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    input  logic                  flush,
    output logic                  W_en,
    output logic [4:0]            Rd,
    output logic [DATA_WIDTH-1:0] Wr_data
);
    logic [1:0]            ptr, p1, p2, sel;
    logic [3:0]            v;
    logic                  any;
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] data;
    logic [31:0]           pending, nxt;

    always_comb begin
        v    = {1'b0, mdu_valid, lsu_valid, alu_valid};
        p1   = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
        p2   = (ptr == 2'd0) ? 2'd2 : ptr - 2'd1;
        sel  = v[ptr] ? ptr : v[p1] ? p1 : p2;
        any  = rst_n && !flush && |v;
        rd   = (sel == 2'd0) ? alu_rd : (sel == 2'd1) ? lsu_rd : mdu_rd;
        data = (sel == 2'd0) ? alu_data : (sel == 2'd1) ? lsu_data : mdu_data;
        nxt  = pending;
        if (any && rd != 5'd0) nxt[rd] = 1'b0;
        // a same-edge issue to the retiring register re-owns it
        if (iss_valid && iss_rd != 5'd0) nxt[iss_rd] = 1'b1;
    end

    assign alu_ready = any && sel == 2'd0;
    assign lsu_ready = any && sel == 2'd1;
    assign mdu_ready = any && sel == 2'd2;
    assign rs1_busy  = (rs1 != 5'd0) && pending[rs1];
    assign rs2_busy  = (rs2 != 5'd0) && pending[rs2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr     <= 2'd0;
            pending <= '0;
            W_en    <= 1'b0;
            Rd      <= 5'd0;
            Wr_data <= '0;
        end else if (flush) begin
            pending <= '0;
            W_en    <= 1'b0;
        end else begin
            pending <= nxt;
            W_en    <= any && rd != 5'd0;
            if (any) begin
                ptr     <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
                Rd      <= rd;
                Wr_data <= data;
            end
        end
    end
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed vectors plus a short random run, checked every
// cycle against a behavioural arbitration/scoreboard model.
module tb_regfile_writeback;
    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
    logic        alu_valid = 0, lsu_valid = 0, mdu_valid = 0, iss_valid = 0;
    logic [4:0]  alu_rd = 0, lsu_rd = 0, mdu_rd = 0, iss_rd = 0, rs1 = 0, rs2 = 0;
    logic [63:0] alu_data = 0, lsu_data = 0, mdu_data = 0;
    logic        alu_ready, lsu_ready, mdu_ready, rs1_busy, rs2_busy, W_en;
    logic [4:0]  Rd;
    logic [63:0] Wr_data;

    int n_chk = 0, n_fail = 0;

    regfile_writeback #(.DATA_WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .flush(flush),
        .W_en(W_en), .Rd(Rd), .Wr_data(Wr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model
    int          m_ptr = 0;
    logic [31:0] m_pend = '0;
    logic        m_wen = 0, m_live = 0;
    logic [4:0]  m_rd = 0;
    logic [63:0] m_data = 0;

    function automatic int grant();
        logic [2:0] vs;
        vs = {mdu_valid, lsu_valid, alu_valid};
        if (!rst_n || flush) return -1;
        for (int k = 0; k < 3; k++)
            if (vs[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
        return -1;
    endfunction

    function automatic logic [4:0] src_rd(int s);
        return s == 0 ? alu_rd : s == 1 ? lsu_rd : mdu_rd;
    endfunction

    function automatic logic [63:0] src_data(int s);
        return s == 0 ? alu_data : s == 1 ? lsu_data : mdu_data;
    endfunction

    always @(posedge clk) begin : model
        int          g;
        logic [4:0]  r;
        logic [31:0] np;
        if (!rst_n) begin
            m_ptr  <= 0;
            m_pend <= '0;
            m_wen  <= 0;
            m_live <= 1;
        end else if (flush) begin
            m_pend <= '0;
            m_wen  <= 0;
        end else begin
            g  = grant();
            np = m_pend;
            m_wen <= 0;
            if (g >= 0) begin
                r = src_rd(g);
                m_ptr <= (g + 1) % 3;
                if (r != 0) begin
                    m_wen  <= 1;
                    m_rd   <= r;
                    m_data <= src_data(g);
                    np[r]  = 1'b0;
                end
            end
            if (iss_valid && iss_rd != 0) np[iss_rd] = 1'b1;
            m_pend <= np;
        end
    end

    always @(negedge clk) begin : compare
        int g;
        if (m_live) begin
            g = grant();
            chk("alu_ready", alu_ready, g == 0);
            chk("lsu_ready", lsu_ready, g == 1);
            chk("mdu_ready", mdu_ready, g == 2);
            chk("rs1_busy", rs1_busy, rs1 != 0 && m_pend[rs1]);
            chk("rs2_busy", rs2_busy, rs2 != 0 && m_pend[rs2]);
            chk("W_en", W_en, m_wen);
            if (m_wen) begin
                chk("Rd", Rd, m_rd);
                chk("Wr_data", Wr_data, m_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_src();
        alu_valid = 0; lsu_valid = 0; mdu_valid = 0; iss_valid = 0; flush = 0;
    endtask

    int          exp_rd[4]  = '{1, 2, 3, 1};
    logic [2:0]  exp_gnt[4] = '{3'b001, 3'b010, 3'b100, 3'b001};

    initial begin
        // reset with every source asserting
        alu_valid = 1; alu_rd = 1; lsu_valid = 1; lsu_rd = 2; mdu_valid = 1; mdu_rd = 3;
        alu_data = 64'h11; lsu_data = 64'h22; mdu_data = 64'h33;
        iss_valid = 1; iss_rd = 4; rs1 = 4; rs2 = 1;
        tick(); tick();
        @(negedge clk);
        chk("rst_grants", {mdu_ready, lsu_ready, alu_ready}, 3'b000);
        chk("rst_W_en", W_en, 0);
        chk("rst_Rd", Rd, 0);
        chk("rst_Wr_data", Wr_data, 0);
        chk("rst_busy", {rs1_busy, rs2_busy}, 2'b00);
        tick();
        // single write
        rst_n = 1; clear_src();
        iss_valid = 1; iss_rd = 5;
        tick();
        iss_valid = 0; rs1 = 5;
        @(negedge clk);
        chk("single_busy_set", rs1_busy, 1);
        tick();
        alu_valid = 1; alu_rd = 5; alu_data = 64'h1234;
        @(negedge clk);
        chk("single_alu_ready", alu_ready, 1);
        tick();
        alu_valid = 0;
        @(negedge clk);
        chk("single_W_en", W_en, 1);
        chk("single_Rd", Rd, 5);
        chk("single_Wr_data", Wr_data, 64'h1234);
        chk("single_busy_clr", rs1_busy, 0);
        tick();
        // rotate pointer back to ALU via an MDU x0 result
        mdu_valid = 1; mdu_rd = 0;
        tick();
        clear_src();
        // round-robin with all three continuously valid
        alu_valid = 1; alu_rd = 1; alu_data = 64'hA1;
        lsu_valid = 1; lsu_rd = 2; lsu_data = 64'hB2;
        mdu_valid = 1; mdu_rd = 3; mdu_data = 64'hC3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_grant", {mdu_ready, lsu_ready, alu_ready}, exp_gnt[i]);
            if (i > 0) begin
                chk("rr_W_en", W_en, 1);
                chk("rr_Rd", Rd, exp_rd[i-1]);
            end
            tick();
        end
        clear_src();
        @(negedge clk);
        chk("rr_last_Rd", Rd, 1);
        chk("rr_last_data", Wr_data, 64'hA1);
        tick();
        // x0 result from LSU
        lsu_valid = 1; lsu_rd = 0; lsu_data = 64'hFF; rs1 = 0;
        @(negedge clk);
        chk("x0_lsu_ready", lsu_ready, 1);
        chk("x0_busy", rs1_busy, 0);
        tick();
        clear_src();
        @(negedge clk);
        chk("x0_W_en", W_en, 0);
        tick();
        alu_valid = 1; alu_rd = 10; lsu_valid = 1; lsu_rd = 11; mdu_valid = 1; mdu_rd = 12;
        @(negedge clk);
        chk("x0_ptr_grant", {mdu_ready, lsu_ready, alu_ready}, 3'b100);
        tick();
        clear_src();
        // set/clear collision on x7
        iss_valid = 1; iss_rd = 7;
        tick();
        mdu_valid = 1; mdu_rd = 7; mdu_data = 64'h77;
        @(negedge clk);
        chk("col_mdu_ready", mdu_ready, 1);
        tick();
        clear_src(); rs1 = 7;
        @(negedge clk);
        chk("col_W_en", W_en, 1);
        chk("col_Rd", Rd, 7);
        chk("col_busy", rs1_busy, 1);
        tick();
        // flush drops scoreboard and blocks grants
        iss_valid = 1; iss_rd = 3;
        tick();
        iss_rd = 9;
        tick();
        iss_rd = 3; alu_valid = 1; alu_rd = 3; alu_data = 64'h33; flush = 1;
        rs1 = 3; rs2 = 9;
        @(negedge clk);
        chk("fl_busy_before", {rs1_busy, rs2_busy}, 2'b11);
        chk("fl_alu_ready", alu_ready, 0);
        tick();
        clear_src();
        @(negedge clk);
        chk("fl_W_en", W_en, 0);
        chk("fl_busy", {rs1_busy, rs2_busy}, 2'b00);
        tick();
        // random traffic checked by the model
        for (int i = 0; i < 200; i++) begin
            alu_valid = 1'($urandom); lsu_valid = 1'($urandom); mdu_valid = 1'($urandom);
            alu_rd = 5'($urandom); lsu_rd = 5'($urandom); mdu_rd = 5'($urandom);
            alu_data = {$urandom, $urandom}; lsu_data = {$urandom, $urandom};
            mdu_data = {$urandom, $urandom};
            iss_valid = 1'($urandom); iss_rd = 5'($urandom);
            rs1 = 5'($urandom); rs2 = 5'($urandom);
            flush = ($urandom_range(0, 15) == 0);
            tick();
        end
        clear_src();
        rst_n = 0; alu_valid = 1;
        tick(); tick();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
